// File: rtl/bundle_coupler.sv
// Pairs consecutive E-record bundles of one run into 2E-record bundles, padding odd tails with max-key records.
// Optional define BUNDLE_COUPLER_ODD_CHK_EN adds a sticky o_odd_err flag for runs with an odd bundle count.

module bundle_coupler_lane #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PAD_REC    = '1
) (
  input  logic                  pad_en,
  input  logic [DATA_WIDTH-1:0] in_rec,
  output logic [DATA_WIDTH-1:0] out_rec
);
  assign out_rec = pad_en ? PAD_REC : in_rec;
endmodule

module bundle_coupler #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEY_WIDTH    = 32,
  parameter int BUNDLE_WIDTH = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH:0]      i_fifo_data,
  input  logic                                  i_fifo_data_vld,
  output logic                                  o_fifo_read,
  input  logic                                  i_fifo_full,
  output logic [2*DATA_WIDTH*BUNDLE_WIDTH:0]    o_fifo_data,
  output logic                                  o_fifo_write
`ifdef BUNDLE_COUPLER_ODD_CHK_EN
  , output logic                                o_odd_err
`endif
);
  localparam int BW = DATA_WIDTH*BUNDLE_WIDTH;
  // Key field all ones, remaining value bits all ones as well.
  localparam logic [DATA_WIDTH-1:0] PAD_REC =
    (DATA_WIDTH'({KEY_WIDTH{1'b1}}) << (DATA_WIDTH-KEY_WIDTH)) | {DATA_WIDTH{1'b1}};

  typedef enum logic {FSM_LOW, FSM_HIGH} state_t;

  state_t                                   state_q, state_d;
  logic [BUNDLE_WIDTH-1:0][DATA_WIDTH-1:0]  hold_q, hold_d;
  logic [BUNDLE_WIDTH-1:0][DATA_WIDTH-1:0]  in_recs, upper_recs;
  logic [2*BW:0]                            data_d;
  logic                                     wr_d, in_last, pad_set;

  assign in_last     = i_fifo_data[BW];
  assign in_recs     = i_fifo_data[BW-1:0];
  assign o_fifo_read = i_fifo_data_vld & ~i_fifo_full & i_rst_n;

  // Upper half is the incoming bundle when completing a pair, pad when closing an odd run.
  for (genvar l = 0; l < BUNDLE_WIDTH; l++) begin : g_lane
    bundle_coupler_lane #(.DATA_WIDTH(DATA_WIDTH), .PAD_REC(PAD_REC)) u_lane (
      .pad_en  (state_q == FSM_LOW),
      .in_rec  (in_recs[l]),
      .out_rec (upper_recs[l])
    );
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = o_fifo_data;
    wr_d    = 1'b0;
    pad_set = 1'b0;
    if (o_fifo_read) begin
      if (state_q == FSM_LOW) begin
        if (in_last) begin
          wr_d    = 1'b1;
          pad_set = 1'b1;
          data_d  = {1'b1, upper_recs, in_recs};
        end else begin
          hold_d  = in_recs;
          state_d = FSM_HIGH;
        end
      end else begin
        wr_d    = 1'b1;
        data_d  = {in_last, upper_recs, hold_q};
        state_d = FSM_LOW;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= FSM_LOW;
      hold_q       <= '0;
      o_fifo_data  <= '0;
      o_fifo_write <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      o_fifo_data  <= data_d;
      o_fifo_write <= wr_d;
    end
  end

`ifdef BUNDLE_COUPLER_ODD_CHK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_odd_err <= 1'b0;
    else          o_odd_err <= o_odd_err | pad_set;
  end
`else
  logic unused_pad_set;
  assign unused_pad_set = pad_set;
`endif
endmodule
